// File: rtl/vram_scheduler.sv
// VRAM arbiter between the CPU video bus and the display prefetch FIFO.
// Define VRAM_STALL_EN to let a starving display FIFO stall the CPU via cpu_wait.
module vram_scheduler #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_rdata,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fetch_base,
    input  logic [15:0]       fetch_len,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underrun,
    output logic              fetch_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 2;

`ifdef VRAM_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              inflight_cpu;
    logic              inflight_disp;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fifo_count;

    logic [LVL_W-1:0]  level;
    logic              fetching;
    logic              room;
    logic              starve;
    logic              cpu_grant;
    logic              disp_grant;
    logic              push;
    logic              pop;

    // Outstanding display reads count against capacity so a returning read always has a slot.
    assign level    = LVL_W'(fifo_count) + LVL_W'(inflight_disp);
    assign fetching = (state == FETCH);
    assign room     = level < LVL_W'(FIFO_DEPTH);
    assign starve   = STALL_EN && fetching && (level < LVL_W'(LOW_WM));

    assign cpu_grant  = rst_n && cpu_req && !starve;
    assign disp_grant = rst_n && fetching && room && (!cpu_req || starve);
    assign cpu_wait   = rst_n && cpu_req && starve;

    assign vram_we    = cpu_grant && cpu_we;
    assign vram_addr  = cpu_grant ? cpu_addr : (disp_grant ? fetch_ptr : last_addr);
    assign vram_wdata = cpu_grant ? cpu_wdata : last_wdata;

    // Read data is presented straight from the VRAM in the return cycle, then held.
    assign cpu_rvalid = inflight_cpu;
    assign cpu_rdata  = inflight_cpu ? vram_rdata : rdata_q;

    assign fetch_busy = fetching;
    assign pix_valid  = (fifo_count != '0);
    assign pix_data   = pix_valid ? fifo_mem[rd_ptr] : '0;

    assign push = inflight_disp && !frame_start;
    assign pop  = pix_pop && pix_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr    <= '0;
            last_wdata   <= '0;
            rdata_q      <= '0;
            inflight_cpu <= 1'b0;
        end else begin
            last_addr    <= vram_addr;
            last_wdata   <= vram_wdata;
            inflight_cpu <= cpu_grant && !cpu_we;
            if (inflight_cpu) begin
                rdata_q <= vram_rdata;
            end
        end
    end

    // A new frame preempts everything, including a display read issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fetch_ptr     <= '0;
            remaining     <= '0;
            inflight_disp <= 1'b0;
        end else begin
            inflight_disp <= disp_grant && !frame_start;
            if (frame_start) begin
                fetch_ptr <= fetch_base;
                remaining <= fetch_len;
                state     <= (fetch_len != 16'd0) ? FETCH : IDLE;
            end else begin
                case (state)
                    FETCH: begin
                        if (disp_grant) begin
                            fetch_ptr <= fetch_ptr + ADDR_W'(1);
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (!inflight_disp) begin
                            state <= IDLE;
                        end
                    end
                    IDLE:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            underrun   <= 1'b0;
        end else if (frame_start) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: ;
            endcase
            if (pix_pop && !pix_valid) begin
                underrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= vram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_scheduler.sv
// Directed bench for vram_scheduler: CPU vector table plus hand-written fetch/reset sequences.
// Builds with or without VRAM_STALL_EN; the CPU-hog and stall sequences follow the build.
module tb_vram_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_wait;
    logic [14:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic        frame_start;
    logic [14:0] fetch_base;
    logic [15:0] fetch_len;
    logic        pix_pop;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        underrun;
    logic        fetch_busy;

    int numChecks = 0;
    int numFails  = 0;

    logic [7:0] vmem [0:32767];

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  expRdata;
    } cpu_vec_t;

    cpu_vec_t cpuVecs [9];

    logic [14:0] expAddrA [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    logic [7:0]  expDataA [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [14:0] expAddrS [5] = '{15'h0500, 15'h0501, 15'h0502, 15'h0503, 15'h06A7};
    logic        expWaitS [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    vram_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_wait    (cpu_wait),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_rdata  (vram_rdata),
        .frame_start (frame_start),
        .fetch_base  (fetch_base),
        .fetch_len   (fetch_len),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous VRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (vram_we) begin
            vmem[vram_addr] <= vram_wdata;
        end
        vram_rdata <= vmem[vram_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input cpu_vec_t v);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " vram_we"},    32'(vram_we),    32'h0);
        checkOutput({tag, " vram_addr"},  32'(vram_addr),  32'h0);
        checkOutput({tag, " vram_wdata"}, 32'(vram_wdata), 32'h0);
        checkOutput({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
        checkOutput({tag, " cpu_rdata"},  32'(cpu_rdata),  32'h0);
        checkOutput({tag, " cpu_wait"},   32'(cpu_wait),   32'h0);
        checkOutput({tag, " pix_valid"},  32'(pix_valid),  32'h0);
        checkOutput({tag, " pix_data"},   32'(pix_data),   32'h0);
        checkOutput({tag, " underrun"},   32'(underrun),   32'h0);
        checkOutput({tag, " fetch_busy"}, 32'(fetch_busy), 32'h0);
    endtask

    initial begin
        cpuVecs[0] = '{1'b1, 15'h1234, 8'hA5, 8'h00};
        cpuVecs[1] = '{1'b0, 15'h1234, 8'h11, 8'hA5};
        cpuVecs[2] = '{1'b0, 15'h0010, 8'h22, 8'h10};
        cpuVecs[3] = '{1'b1, 15'h7FF0, 8'h3C, 8'h00};
        cpuVecs[4] = '{1'b0, 15'h7FF0, 8'h00, 8'h3C};
        cpuVecs[5] = '{1'b0, 15'h0000, 8'h00, 8'h00};
        cpuVecs[6] = '{1'b1, 15'h4000, 8'hFF, 8'h00};
        cpuVecs[7] = '{1'b0, 15'h4000, 8'h5A, 8'hFF};
        cpuVecs[8] = '{1'b0, 15'h2ABC, 8'h00, 8'hBC};

        for (int i = 0; i < 32768; i++) begin
            vmem[i] = 8'(i);
        end

        // Reset with a CPU write pending: everything must read zero.
        rst_n       = 1'b0;
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 15'h1111;
        cpu_wdata   = 8'h77;
        frame_start = 1'b0;
        fetch_base  = '0;
        fetch_len   = '0;
        pix_pop     = 1'b0;
        repeat (2) @(negedge clk);
        #1 checkAllZero("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;

        // CPU access table with the fetch engine idle.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            applyStimulus(cpuVecs[i]);
            #1;
            checkOutput("cpu vram_addr",  32'(vram_addr),  32'(cpuVecs[i].addr));
            checkOutput("cpu vram_we",    32'(vram_we),    32'(cpuVecs[i].we));
            checkOutput("cpu vram_wdata", 32'(vram_wdata), 32'(cpuVecs[i].wdata));
            checkOutput("cpu cpu_wait",   32'(cpu_wait),   32'h0);
            @(negedge clk);
            cpu_req = 1'b0;
            #1;
            checkOutput("cpu rvalid",     32'(cpu_rvalid), 32'(!cpuVecs[i].we));
            if (!cpuVecs[i].we) begin
                checkOutput("cpu rdata", 32'(cpu_rdata), 32'(cpuVecs[i].expRdata));
            end
            checkOutput("idle vram_we",   32'(vram_we),    32'h0);
            checkOutput("idle addr hold", 32'(vram_addr),  32'(cpuVecs[i].addr));
        end

        // Fetch across the top of the address space.
        @(negedge clk);
        frame_start = 1'b1;
        fetch_base  = 15'h7FFE;
        fetch_len   = 16'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            #1;
            checkOutput("wrap fetch addr", 32'(vram_addr),  32'(expAddrA[k]));
            checkOutput("wrap fetch busy", 32'(fetch_busy), 32'h1);
        end
        @(negedge clk);
        #1;
        checkOutput("wrap done busy", 32'(fetch_busy), 32'h0);
        checkOutput("wrap addr hold", 32'(vram_addr),  32'h0001);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("wrap pix_valid", 32'(pix_valid), 32'h1);
            checkOutput("wrap pix_data",  32'(pix_data),  32'(expDataA[k]));
            pix_pop = 1'b1;
            @(negedge clk);
        end
        pix_pop = 1'b0;
        #1;
        checkOutput("wrap drained", 32'(pix_valid), 32'h0);
        checkOutput("wrap underrun", 32'(underrun), 32'h0);

        // Long frame with no pops: fill to capacity, then one pop buys exactly one read.
        @(negedge clk);
        frame_start = 1'b1;
        fetch_base  = 15'h0100;
        fetch_len   = 16'd40;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        checkOutput("full last addr", 32'(vram_addr),  32'h010F);
        checkOutput("full busy",      32'(fetch_busy), 32'h1);
        checkOutput("full head",      32'(pix_data),   32'h00);
        pix_pop = 1'b1;
        @(negedge clk);
        pix_pop = 1'b0;
        #1;
        checkOutput("refill addr", 32'(vram_addr), 32'h0110);
        checkOutput("refill head", 32'(pix_data),  32'h01);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("refill single read", 32'(vram_addr), 32'h0110);

`ifndef VRAM_STALL_EN
        // CPU hogs the bus: new frame flushes the FIFO but no display reads occur.
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 15'h0200;
        frame_start = 1'b1;
        fetch_base  = 15'h0300;
        fetch_len   = 16'd8;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            #1;
            checkOutput("hog vram_addr", 32'(vram_addr), 32'h0200);
        end
        checkOutput("hog flushed",   32'(pix_valid),  32'h0);
        checkOutput("hog busy",      32'(fetch_busy), 32'h1);
        checkOutput("hog cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        pix_pop = 1'b1;
        @(negedge clk);
        pix_pop = 1'b0;
        #1;
        checkOutput("underrun set", 32'(underrun), 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        checkOutput("hog release addr", 32'(vram_addr), 32'h0300);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("release pix_valid", 32'(pix_valid), 32'h1);
        checkOutput("release pix_data",  32'(pix_data),  32'h00);
        checkOutput("underrun sticky",   32'(underrun),  32'h1);
        @(negedge clk);
        frame_start = 1'b1;
        fetch_base  = 15'h0455;
        fetch_len   = 16'd2;
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        checkOutput("restart flushed",  32'(pix_valid),  32'h0);
        checkOutput("underrun cleared", 32'(underrun),   32'h0);
        checkOutput("restart addr0",    32'(vram_addr),  32'h0455);
        @(negedge clk);
        #1;
        checkOutput("restart addr1", 32'(vram_addr), 32'h0456);
        @(negedge clk);
        #1;
        checkOutput("restart head",      32'(pix_data),   32'h55);
        checkOutput("restart done busy", 32'(fetch_busy), 32'h0);
`else
        // Starving FIFO stalls the CPU until the level reaches the low watermark.
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 15'h06A7;
        frame_start = 1'b1;
        fetch_base  = 15'h0500;
        fetch_len   = 16'd20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            #1;
            checkOutput("stall vram_addr", 32'(vram_addr), 32'(expAddrS[k]));
            checkOutput("stall cpu_wait",  32'(cpu_wait),  32'(expWaitS[k]));
        end
        @(negedge clk);
        #1;
        checkOutput("stall rvalid", 32'(cpu_rvalid), 32'h1);
        checkOutput("stall rdata",  32'(cpu_rdata),  32'hA7);
        cpu_req = 1'b0;
`endif

        // Reset in the middle of a fetch with five bytes buffered.
        @(negedge clk);
        cpu_req     = 1'b0;
        frame_start = 1'b1;
        fetch_base  = 15'h0010;
        fetch_len   = 16'd20;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("midfetch head", 32'(pix_data), 32'h10);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 15'h2222;
        cpu_wdata = 8'h99;
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("midfetch reset");
        @(negedge clk);
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("post reset pix_valid", 32'(pix_valid),   32'h0);
        checkOutput("post reset busy",      32'(fetch_busy),  32'h0);
        checkOutput("post reset addr",      32'(vram_addr),   32'h0);
        checkOutput("no write in reset",    32'(vmem[15'h2222]), 32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
